// File: rtl/crypto_wallet_sw_debounce.sv
// crypto_wallet_sw_debounce: synchronises raw slide-switch levels into clk, debounces each bit
// independently and emits a one-cycle pulse per bit whenever its clean level changes.
module crypto_wallet_sw_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_changed
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_param
        $error("crypto_wallet_sw_debounce: DEBOUNCE_CYCLES=%0d out of range for CNT_W=%0d",
               DEBOUNCE_CYCLES, CNT_W);
    end

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] done;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];

    // A counter only runs while the synchronised level disagrees with the accepted one,
    // so any return to the accepted level restarts qualification from zero.
    always_comb begin
        done = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != sw_stable[i]) begin
                done[i]     = (cnt[i] == LAST);
                cnt_next[i] = done[i] ? '0 : cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            sw_stable  <= '0;
            sw_changed <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            sync1      <= sw_raw;
            sync2      <= sync1;
            sw_stable  <= sw_stable ^ done;
            sw_changed <= done;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
        end
    end
endmodule

// File: tb/tb_crypto_wallet_sw_debounce.sv
// tb_crypto_wallet_sw_debounce: directed checks of the switch debouncer with DEBOUNCE_CYCLES=8.
module tb_crypto_wallet_sw_debounce;
    logic       clk;
    logic       reset_n;
    logic [3:0] sw_raw;
    logic [3:0] sw_stable;
    logic [3:0] sw_changed;
    logic [3:0] seen;
    int         total;
    int         bad;

    crypto_wallet_sw_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .CNT_W(20)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sw_raw(sw_raw),
        .sw_stable(sw_stable),
        .sw_changed(sw_changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            seen = seen | sw_changed;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        seen    = '0;
        reset_n = 1'b0;
        sw_raw  = 4'hF;
        // power-up with all switches high
        tick(3);
        chk("rst_stable", sw_stable, 4'h0);
        chk("rst_changed", sw_changed, 4'h0);
        reset_n = 1'b1;
        tick(9);
        chk("pwr_stable_e9", sw_stable, 4'h0);
        tick(1);
        chk("pwr_stable_e10", sw_stable, 4'hF);
        chk("pwr_changed_e10", sw_changed, 4'hF);
        tick(1);
        chk("pwr_changed_e11", sw_changed, 4'h0);
        // clean step
        sw_raw = 4'h0;
        tick(12);
        chk("clear_stable", sw_stable, 4'h0);
        sw_raw = 4'b0001;
        tick(9);
        chk("step_stable_e8", sw_stable, 4'b0000);
        chk("step_changed_e8", sw_changed, 4'b0000);
        tick(1);
        chk("step_stable_e9", sw_stable, 4'b0001);
        chk("step_changed_e9", sw_changed, 4'b0001);
        tick(1);
        chk("step_changed_e10", sw_changed, 4'b0000);
        // glitches on bit1
        seen   = '0;
        sw_raw = 4'b0011;
        tick(5);
        sw_raw = 4'b0001;
        tick(12);
        chk("glitch5_stable", sw_stable, 4'b0001);
        chk("glitch5_seen", seen, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            sw_raw = 4'b0011;
            tick(7);
            sw_raw = 4'b0001;
            tick(1);
            chk("bounce7_stable", sw_stable, 4'b0001);
        end
        tick(12);
        chk("bounce7_stable_end", sw_stable, 4'b0001);
        chk("bounce7_seen", seen, 4'b0000);
        // bounce then settle on bit2
        seen = '0;
        for (int k = 0; k < 6; k++) begin
            sw_raw[2] = ~sw_raw[2];
            tick(3);
        end
        sw_raw[2] = 1'b1;
        tick(9);
        chk("settle_stable_e9", sw_stable, 4'b0001);
        chk("settle_seen", seen, 4'b0000);
        tick(1);
        chk("settle_stable_e10", sw_stable, 4'b0101);
        chk("settle_changed_e10", sw_changed, 4'b0100);
        tick(1);
        chk("settle_changed_e11", sw_changed, 4'b0000);
        // independent bits, then simultaneous drop
        sw_raw = 4'b0000;
        tick(12);
        chk("indep_clear", sw_stable, 4'b0000);
        sw_raw = 4'b0001;
        tick(3);
        sw_raw = 4'b1001;
        tick(6);
        chk("indep_changed_e8", sw_changed, 4'b0000);
        tick(1);
        chk("indep_changed_e9", sw_changed, 4'b0001);
        chk("indep_stable_e9", sw_stable, 4'b0001);
        tick(2);
        chk("indep_changed_e11", sw_changed, 4'b0000);
        tick(1);
        chk("indep_changed_e12", sw_changed, 4'b1000);
        chk("indep_stable_e12", sw_stable, 4'b1001);
        sw_raw = 4'b0000;
        tick(9);
        chk("drop_changed_e8", sw_changed, 4'b0000);
        chk("drop_stable_e8", sw_stable, 4'b1001);
        tick(1);
        chk("drop_changed_e9", sw_changed, 4'b1001);
        chk("drop_stable_e9", sw_stable, 4'b0000);
        // asynchronous reset in the middle of a count
        sw_raw = 4'b0001;
        tick(12);
        chk("mid_pre_stable", sw_stable, 4'b0001);
        sw_raw = 4'b0011;
        tick(5);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_async_stable", sw_stable, 4'b0000);
        chk("mid_async_changed", sw_changed, 4'b0000);
        tick(2);
        chk("mid_held_stable", sw_stable, 4'b0000);
        reset_n = 1'b1;
        tick(9);
        chk("mid_stable_e9", sw_stable, 4'b0000);
        tick(1);
        chk("mid_stable_e10", sw_stable, 4'b0011);
        chk("mid_changed_e10", sw_changed, 4'b0011);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
